// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Captures decoded control and operands from decode and presents them to
// execute one cycle later. Detects load-use hazards against the instruction
// in EX and applies the bubble/flush/hold policy. It also drives stall and
// flush requests back to the PC and the IF/ID register.
//
// Optional feature macro: HAZARD_CNT_EN. When defined, it adds the BubbleCnt
// and FlushCnt event counters.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   CtrlD / CtrlE                packed control bundle
//                                {RegWrite, ResultSrc, MemWrite, Jump, Branch,
//                                 ALUctrl[2:0], ALUsrc, MUXJUMP, JUMPRT, BranchMUX}
//   ValidD / ValidE              slot holds a real instruction
//   RD1*, RD2*, PC*, ImmExt*,
//   PCPlus4*                     operand/address data, decode -> execute
//   Rs1*, Rs2*, Rd*              register specifiers, decode -> execute
//   PCSrcE                       taken branch/jump resolved in EX
//   HoldIn                       external stall, freezes this stage
//   StallF, StallD               hold PC / hold IF/ID
//   FlushD                       clear IF/ID
//   BubbleCnt, FlushCnt          (HAZARD_CNT_EN only) hazard event counters
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CTRL_WIDTH-1:0]     CtrlD,
  input  logic                      ValidD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      PCSrcE,
  input  logic                      HoldIn,
  output logic [CTRL_WIDTH-1:0]     CtrlE,
  output logic                      ValidE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD
`ifdef HAZARD_CNT_EN
  ,
  output logic [31:0]               BubbleCnt,
  output logic [31:0]               FlushCnt
`endif
);

  // ResultSrc is the second-highest bit of the control bundle; it marks a load.
  localparam int RESULT_SRC_BIT = CTRL_WIDTH - 2;

  logic ld_use;
  logic load_bubble;

  // Conservative compare: any register match is a hazard, whether or not the
  // decode instruction actually reads that source. x0 is never a dependence.
  assign ld_use = ValidE & CtrlE[RESULT_SRC_BIT] & (RdE != '0) & ValidD &
                  ((RdE == Rs1D) | (RdE == Rs2D));

  assign FlushD = PCSrcE;
  // A taken branch discards the decode instruction, so it cannot stall on it.
  assign StallF = (ld_use & ~PCSrcE) | HoldIn;
  assign StallD = StallF;

  // Hold beats both flush and load-use. A pending flush is applied on the
  // first non-held edge because PCSrcE stays asserted from EX.
  assign load_bubble = ~HoldIn & (PCSrcE | ld_use);

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      CtrlE    <= '0;
      ValidE   <= 1'b0;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (!HoldIn) begin
      CtrlE    <= ValidD ? CtrlD : '0;
      ValidE   <= ValidD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
    end
  end

`ifdef HAZARD_CNT_EN
  // Both counters wrap naturally and are frozen while HoldIn is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      BubbleCnt <= '0;
      FlushCnt  <= '0;
    end else if (!HoldIn) begin
      if (PCSrcE)
        FlushCnt <= FlushCnt + 32'd1;
      else if (ld_use)
        BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] CtrlD;
  logic        ValidD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        PCSrcE, HoldIn;
  logic [11:0] CtrlE;
  logic        ValidE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        StallF, StallD, FlushD;
`ifdef HAZARD_CNT_EN
  logic [31:0] BubbleCnt, FlushCnt;
`endif

  int tests  = 0;
  int failed = 0;
  int exp_bubble = 0;
  int exp_flush  = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .CtrlD(CtrlD), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .PCSrcE(PCSrcE), .HoldIn(HoldIn),
    .CtrlE(CtrlE), .ValidE(ValidE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
`ifdef HAZARD_CNT_EN
    ,
    .BubbleCnt(BubbleCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] ctrl, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] rd1);
    CtrlD    = ctrl;
    ValidD   = v;
    Rs1D     = rs1;
    Rs2D     = rs2;
    RdD      = rd;
    RD1D     = rd1;
    RD2D     = rd1 ^ 32'hFFFF_0000;
    PCD      = {rd1[29:0], 2'b00};
    ImmExtD  = rd1 + 32'd7;
    PCPlus4D = {rd1[29:0], 2'b00} + 32'd4;
    #1;
  endtask

  task automatic check_counters(input string name);
`ifdef HAZARD_CNT_EN
    tests++;
    if (BubbleCnt !== exp_bubble) begin
      failed++;
      $display("FAIL %s BubbleCnt: got %0d expected %0d", name, BubbleCnt, exp_bubble);
    end
    tests++;
    if (FlushCnt !== exp_flush) begin
      failed++;
      $display("FAIL %s FlushCnt: got %0d expected %0d", name, FlushCnt, exp_flush);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic check_bubble(input string name);
    tests++;
    if (CtrlE !== 12'h000 || ValidE !== 1'b0 || RdE !== 5'd0) begin
      failed++;
      $display("FAIL %s bubble: got ctrl=%h valid=%b rd=%0d expected ctrl=000 valid=0 rd=0",
               name, CtrlE, ValidE, RdE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    PCSrcE = 1'b0;
    HoldIn = 1'b0;
    drive(12'($urandom), 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    step();
    drive(12'($urandom), 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    step();
    tests++;
    if (CtrlE !== 0 || ValidE !== 0 || RD1E !== 0 || RD2E !== 0 || PCE !== 0 ||
        ImmExtE !== 0 || PCPlus4E !== 0 || Rs1E !== 0 || Rs2E !== 0 || RdE !== 0) begin
      failed++;
      $display("FAIL reset_regs: got ctrl=%h v=%b rd1=%h rd2=%h pc=%h rd=%0d expected all 0",
               CtrlE, ValidE, RD1E, RD2E, PCE, RdE);
    end
    tests++;
    if (StallF !== 0 || StallD !== 0 || FlushD !== 0) begin
      failed++;
      $display("FAIL reset_ctl: got stallf=%b stalld=%b flushd=%b expected 0 0 0",
               StallF, StallD, FlushD);
    end
    check_counters("reset");
    rst = 1'b0;
  endtask

  task automatic test_normal();
    drive(12'h800, 1'b1, 5'd1, 5'd2, 5'd5, 32'h11);
    tests++;
    if (StallF !== 0 || StallD !== 0) begin
      failed++;
      $display("FAIL normal_nostall: got stallf=%b stalld=%b expected 0 0", StallF, StallD);
    end
    step();
    tests++;
    if (CtrlE !== 12'h800 || RD1E !== 32'h11 || RdE !== 5'd5 || ValidE !== 1'b1 ||
        PCE !== 32'h44 || ImmExtE !== 32'h18 || PCPlus4E !== 32'h48 ||
        RD2E !== 32'hFFFF_0011 || Rs1E !== 5'd1 || Rs2E !== 5'd2) begin
      failed++;
      $display("FAIL normal_capture: got ctrl=%h rd1=%h rd=%0d v=%b pc=%h imm=%h expected 800 11 5 1 44 18",
               CtrlE, RD1E, RdE, ValidE, PCE, ImmExtE);
    end
  endtask

  task automatic test_load_use();
    drive(12'hC00, 1'b1, 5'd1, 5'd2, 5'd6, 32'h20);
    step();
    drive(12'h800, 1'b1, 5'd7, 5'd6, 5'd8, 32'h30);
    tests++;
    if (StallF !== 1 || StallD !== 1 || FlushD !== 0) begin
      failed++;
      $display("FAIL loaduse_stall: got stallf=%b stalld=%b flushd=%b expected 1 1 0",
               StallF, StallD, FlushD);
    end
    step();
    exp_bubble++;
    check_bubble("loaduse");
    tests++;
    if (StallF !== 0) begin
      failed++;
      $display("FAIL loaduse_release: got stallf=%b expected 0", StallF);
    end
    step();
    tests++;
    if (CtrlE !== 12'h800 || ValidE !== 1 || RdE !== 5'd8 || RD1E !== 32'h30) begin
      failed++;
      $display("FAIL loaduse_capture: got ctrl=%h v=%b rd=%0d rd1=%h expected 800 1 8 30",
               CtrlE, ValidE, RdE, RD1E);
    end
    check_counters("loaduse");
  endtask

  task automatic test_x0_load();
    drive(12'hC00, 1'b1, 5'd1, 5'd2, 5'd0, 32'h40);
    step();
    drive(12'h800, 1'b1, 5'd0, 5'd3, 5'd9, 32'h50);
    tests++;
    if (StallF !== 0 || StallD !== 0) begin
      failed++;
      $display("FAIL x0_nostall: got stallf=%b stalld=%b expected 0 0", StallF, StallD);
    end
    step();
    tests++;
    if (CtrlE !== 12'h800 || ValidE !== 1 || RdE !== 5'd9) begin
      failed++;
      $display("FAIL x0_capture: got ctrl=%h v=%b rd=%0d expected 800 1 9", CtrlE, ValidE, RdE);
    end
  endtask

  task automatic test_invalid_decode();
    drive(12'hFFF, 1'b0, 5'd4, 5'd4, 5'd4, 32'h60);
    step();
    tests++;
    if (CtrlE !== 12'h000 || ValidE !== 0 || RD1E !== 32'h60 || RdE !== 5'd4) begin
      failed++;
      $display("FAIL invalid_decode: got ctrl=%h v=%b rd1=%h rd=%0d expected 000 0 60 4",
               CtrlE, ValidE, RD1E, RdE);
    end
  endtask

  task automatic test_flush();
    drive(12'hC00, 1'b1, 5'd1, 5'd2, 5'd6, 32'h70);
    step();
    drive(12'h800, 1'b1, 5'd6, 5'd2, 5'd3, 32'h80);
    PCSrcE = 1'b1;
    #1;
    tests++;
    if (FlushD !== 1 || StallF !== 0 || StallD !== 0) begin
      failed++;
      $display("FAIL flush_comb: got flushd=%b stallf=%b stalld=%b expected 1 0 0",
               FlushD, StallF, StallD);
    end
    step();
    exp_flush++;
    check_bubble("flush");
    PCSrcE = 1'b0;
    #1;
    tests++;
    if (FlushD !== 0) begin
      failed++;
      $display("FAIL flush_drop: got flushd=%b expected 0", FlushD);
    end
    check_counters("flush");
  endtask

  task automatic test_hold_flush();
    drive(12'h8F0, 1'b1, 5'd1, 5'd2, 5'd10, 32'h55);
    step();
    drive(12'hC00, 1'b1, 5'd10, 5'd10, 5'd11, 32'h99);
    HoldIn = 1'b1;
    PCSrcE = 1'b1;
    #1;
    tests++;
    if (StallF !== 1 || StallD !== 1 || FlushD !== 1) begin
      failed++;
      $display("FAIL hold_comb: got stallf=%b stalld=%b flushd=%b expected 1 1 1",
               StallF, StallD, FlushD);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (CtrlE !== 12'h8F0 || ValidE !== 1 || RdE !== 5'd10 || RD1E !== 32'h55) begin
        failed++;
        $display("FAIL hold_keep%0d: got ctrl=%h v=%b rd=%0d rd1=%h expected 8F0 1 10 55",
                 i, CtrlE, ValidE, RdE, RD1E);
      end
    end
    check_counters("hold");
    HoldIn = 1'b0;
    #1;
    tests++;
    if (StallF !== 0 || FlushD !== 1) begin
      failed++;
      $display("FAIL hold_release_comb: got stallf=%b flushd=%b expected 0 1", StallF, FlushD);
    end
    step();
    exp_flush++;
    check_bubble("hold_release");
    check_counters("hold_release");
    PCSrcE = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(12'hC00, 1'b1, 5'd1, 5'd2, 5'd6, 32'hA0);
    step();
    drive(12'h800, 1'b1, 5'd3, 5'd6, 5'd12, 32'hB0);
    tests++;
    if (StallF !== 1) begin
      failed++;
      $display("FAIL midstall_pre: got stallf=%b expected 1", StallF);
    end
    rst = 1'b1;
    step();
    exp_bubble = 0;
    exp_flush  = 0;
    check_bubble("midstall_reset");
    tests++;
    if (StallF !== 0 || StallD !== 0 || RD1E !== 0) begin
      failed++;
      $display("FAIL midstall_post: got stallf=%b stalld=%b rd1=%h expected 0 0 0",
               StallF, StallD, RD1E);
    end
    check_counters("midstall_reset");
    rst = 1'b0;
    step();
    tests++;
    if (CtrlE !== 12'h800 || ValidE !== 1 || RdE !== 5'd12) begin
      failed++;
      $display("FAIL midstall_resume: got ctrl=%h v=%b rd=%0d expected 800 1 12",
               CtrlE, ValidE, RdE);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal();
    test_load_use();
    test_x0_load();
    test_invalid_decode();
    test_flush();
    test_hold_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the pipelined RV32I core, fed directly by the decode-stage control unit and register file.
- Captures decoded control and operands each cycle and presents them to the execute stage.
- Contains the load-use hazard detector and applies the bubble/flush/hold policy for EX.
- Drives the stall and flush requests back to the IF/ID register and the PC.

Parameters:
- DATA_WIDTH, 32, width of operands, PC, immediate and PC+4.
- REG_ADDR_WIDTH, 5, width of register specifiers.
- CTRL_WIDTH, 12, width of the packed control bundle.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- CtrlD  in  CTRL_WIDTH  decode control bundle, MSB..LSB = {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUctrl[2:0], ALUsrc, MUXJUMP, JUMPRT, BranchMUX}.
- ValidD  in  1  decode slot holds a real instruction.
- RD1D, RD2D  in  DATA_WIDTH  register-file read data.
- PCD, ImmExtD, PCPlus4D  in  DATA_WIDTH  decode PC, extended immediate, PC+4.
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  register specifiers of the decode instruction.
- PCSrcE  in  1  taken branch/jump resolved in EX this cycle.
- HoldIn  in  1  external stall (memory wait); freezes this stage.
- CtrlE  out  CTRL_WIDTH  registered control bundle.
- ValidE  out  1  registered valid.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  out  DATA_WIDTH  registered data.
- Rs1E, Rs2E, RdE  out  REG_ADDR_WIDTH  registered specifiers.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  clear IF/ID.

Behaviour:
- Reset (rst=1 at edge): all registered outputs become 0, including CtrlE, ValidE, the data fields and the specifiers. The stage then holds a bubble.
- Bubble definition: CtrlE=0, ValidE=0, RdE=0. Data fields are don't-care; the implementation clears them to 0.
- Load-use detect (combinational):
  - LdUse = ValidE & CtrlE.ResultSrc & (RdE != 0) & ValidD & ((RdE == Rs1D) | (RdE == Rs2D)).
  - The compare is conservative: no per-opcode rs-usage filtering.
- Outputs to upstream (combinational, same cycle):
  - FlushD = PCSrcE.
  - StallF = StallD = (LdUse & ~PCSrcE) | HoldIn.
- Register update, by priority at each rising edge:
  1. rst: reset values.
  2. PCSrcE & ~HoldIn: load a bubble; the wrong-path decode instruction is discarded.
  3. HoldIn: all E registers keep their value.
  4. LdUse: load a bubble. IF/ID and the PC are held by StallD/StallF, so the decode instruction re-presents next cycle.
  5. Otherwise: capture all D inputs. ValidE = ValidD. If ValidD=0, CtrlE is forced to 0.
- Latency: exactly one cycle from D inputs to E outputs. The stage holds no extra buffering.
- Load-use penalty: exactly one bubble. The cycle after the bubble, LdUse is 0 because ValidE=0.
- HoldIn & PCSrcE in the same cycle: hold wins. PCSrcE stays asserted from EX and the flush is applied on the first non-held edge. FlushD still follows PCSrcE combinationally.
- Reset mid-stall: rst overrides everything. StallF/StallD fall to 0 the cycle after reset unless HoldIn is asserted.
- RdE = 0: never triggers LdUse (x0 is not a dependence).

Optional Feature:
- Macro: HAZARD_CNT_EN.
- When defined:
  - Adds outputs BubbleCnt [31:0] and FlushCnt [31:0].
  - BubbleCnt increments on every edge where rule 4 applies; FlushCnt increments on every edge where rule 2 applies.
  - Both counters clear on rst and wrap from 0xFFFFFFFF to 0.
  - Both counters are frozen while HoldIn is asserted.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all E outputs 0, StallF=StallD=FlushD=0.
- Normal flow: ValidD=1, CtrlD=12'h800, RD1D=0x11, RdD=5 -> next cycle CtrlE=12'h800, RD1E=0x11, RdE=5, ValidE=1, no stalls.
- Load-use: lw x6 in EX (ResultSrc=1, RdE=6), decode add with Rs2D=6 -> StallF=StallD=1 for one cycle; next cycle ValidE=0, CtrlE=0; the following cycle the add is captured and StallF=0.
- x0 load: lw x0 in EX, decode Rs1D=0 -> no stall; decode captured next cycle.
- Branch flush: PCSrcE=1 with a valid decode instruction -> FlushD=1 same cycle, next-cycle ValidE=0, CtrlE=0.
- Hold vs flush: HoldIn=1 and PCSrcE=1 for 2 cycles, then HoldIn=0 -> E registers unchanged during the hold, bubble loaded on the release edge. With HAZARD_CNT_EN: FlushCnt=1, BubbleCnt unchanged.
